// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/almost flags and drop/underflow pulses.
// Define SYNC_FIFO_STATS_EN to build the saturating drop/underflow counters.
module sync_fifo #(
  parameter int DATA_WIDTH          = 8,
  parameter int ADDR_SIZE           = 4,
  parameter int ALMOST_FULL_THRESH  = (1 << ADDR_SIZE) - 2,
  parameter int ALMOST_EMPTY_THRESH = 1,
  parameter int CNT_WIDTH           = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_inc,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_full,
  output logic                  w_almost_full,
  output logic                  w_dropped,
  input  logic                  r_inc,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_empty,
  output logic                  r_almost_empty,
  output logic                  r_underflow,
  output logic [ADDR_SIZE:0]    count,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic [CNT_WIDTH-1:0]  underflow_cnt
);

  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] DEPTH_C = (ADDR_SIZE+1)'(DEPTH);
  localparam logic [ADDR_SIZE:0] AF_C    = (ADDR_SIZE+1)'(ALMOST_FULL_THRESH);
  localparam logic [ADDR_SIZE:0] AE_C    = (ADDR_SIZE+1)'(ALMOST_EMPTY_THRESH);
  localparam logic [ADDR_SIZE:0] ONE_C   = (ADDR_SIZE+1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_SIZE:0]    w_ptr, r_ptr, count_next;
  logic                  do_write, do_read;

  assign do_write = w_inc & ~w_full;
  assign do_read  = r_inc & ~r_empty;
  assign r_data   = mem[r_ptr[ADDR_SIZE-1:0]];

  always_comb begin
    count_next = count;
    case ({do_write, do_read})
      2'b10:   count_next = count + ONE_C;
      2'b01:   count_next = count - ONE_C;
      default: count_next = count;
    endcase
  end

  // Storage carries no reset; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_write) mem[w_ptr[ADDR_SIZE-1:0]] <= w_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr          <= '0;
      r_ptr          <= '0;
      count          <= '0;
      w_full         <= 1'b0;
      w_almost_full  <= 1'b0;
      w_dropped      <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_underflow    <= 1'b0;
    end else begin
      if (do_write) w_ptr <= w_ptr + ONE_C;
      if (do_read)  r_ptr <= r_ptr + ONE_C;
      count          <= count_next;
      w_full         <= (count_next == DEPTH_C);
      r_empty        <= (count_next == '0);
      w_almost_full  <= (count_next >= AF_C);
      r_almost_empty <= (count_next <= AE_C);
      w_dropped      <= w_inc & w_full;
      r_underflow    <= r_inc & r_empty;
    end
  end

`ifdef SYNC_FIFO_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  // Counters step on the same edge that raises the matching pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt      <= '0;
      underflow_cnt <= '0;
    end else begin
      if (w_inc && w_full && (drop_cnt != '1))       drop_cnt      <= drop_cnt + CNT_ONE;
      if (r_inc && r_empty && (underflow_cnt != '1)) underflow_cnt <= underflow_cnt + CNT_ONE;
    end
  end
`else
  assign drop_cnt      = '0;
  assign underflow_cnt = '0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo at DEPTH 4 with hand-computed expectations.
module tb_sync_fifo;

  localparam int DW = 8;
  localparam int AS = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          w_inc = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic          r_inc = 1'b0;
  logic          w_full, w_almost_full, w_dropped;
  logic [DW-1:0] r_data;
  logic          r_empty, r_almost_empty, r_underflow;
  logic [AS:0]   count;
  logic [CW-1:0] drop_cnt, underflow_cnt;

  int n_vec = 0;
  int n_err = 0;

  sync_fifo #(
    .DATA_WIDTH(DW), .ADDR_SIZE(AS), .ALMOST_FULL_THRESH(3),
    .ALMOST_EMPTY_THRESH(1), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .w_inc(w_inc), .w_data(w_data), .w_full(w_full),
    .w_almost_full(w_almost_full), .w_dropped(w_dropped),
    .r_inc(r_inc), .r_data(r_data), .r_empty(r_empty),
    .r_almost_empty(r_almost_empty), .r_underflow(r_underflow),
    .count(count), .drop_cnt(drop_cnt), .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given requests; returns 1 time unit after the edge.
  task automatic step(input logic w, input logic [DW-1:0] wd, input logic r);
    w_inc = w; w_data = wd; r_inc = r;
    @(posedge clk); #1;
    w_inc = 1'b0; r_inc = 1'b0;
  endtask

  task automatic chk_ptrs(input string tag);
    logic [AS:0] diff;
    diff = dut.w_ptr - dut.r_ptr;
    chk(tag, {29'd0, count}, {29'd0, diff});
  endtask

  localparam logic [CW-1:0] ONE_IF_STATS =
`ifdef SYNC_FIFO_STATS_EN
    CW'(1);
`else
    CW'(0);
`endif

  initial begin
    logic [DW-1:0] wv [4];
    wv[0] = 8'h11; wv[1] = 8'h22; wv[2] = 8'h33; wv[3] = 8'h44;

    // reset state
    #12;
    chk("rst_count", count, 0);
    chk("rst_empty", r_empty, 1);
    chk("rst_ae", r_almost_empty, 1);
    chk("rst_full", w_full, 0);
    chk("rst_af", w_almost_full, 0);
    chk("rst_drop", w_dropped, 0);
    chk("rst_uf", r_underflow, 0);
    chk("rst_dcnt", drop_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // fill
    for (int i = 0; i < 4; i++) begin
      step(1'b1, wv[i], 1'b0);
      chk("fill_count", count, i + 1);
      chk("fill_af", w_almost_full, (i >= 2) ? 1 : 0);
      chk("fill_full", w_full, (i == 3) ? 1 : 0);
      chk("fill_ae", r_almost_empty, (i == 0) ? 1 : 0);
      chk("fill_empty", r_empty, 0);
      chk("fill_head", r_data, 8'h11);
    end

    // write while full
    step(1'b1, 8'h55, 1'b0);
    chk("ovf_drop", w_dropped, 1);
    chk("ovf_count", count, 4);
    chk("ovf_head", r_data, 8'h11);
    step(1'b0, 8'h00, 1'b0);
    chk("ovf_pulse_end", w_dropped, 0);
    chk("ovf_dcnt", drop_cnt, ONE_IF_STATS);

    // drain in order
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", r_data, wv[i]);
      step(1'b0, 8'h00, 1'b1);
      chk("drain_count", count, 3 - i);
    end
    chk("drain_empty", r_empty, 1);

    // pop while empty
    step(1'b0, 8'h00, 1'b1);
    chk("uf_pulse", r_underflow, 1);
    chk("uf_count", count, 0);
    step(1'b0, 8'h00, 1'b0);
    chk("uf_pulse_end", r_underflow, 0);
    chk("uf_ucnt", underflow_cnt, ONE_IF_STATS);

    // empty with simultaneous write and pop
    step(1'b1, 8'hA5, 1'b1);
    chk("ewr_count", count, 1);
    chk("ewr_data", r_data, 8'hA5);
    chk("ewr_uf", r_underflow, 1);
    chk("ewr_empty", r_empty, 0);

    // fill to full, then simultaneous write and pop
    step(1'b1, 8'hB1, 1'b0);
    step(1'b1, 8'hB2, 1'b0);
    step(1'b1, 8'hB3, 1'b0);
    chk("pre_full", w_full, 1);
    step(1'b1, 8'h66, 1'b1);
    chk("fwr_count", count, 3);
    chk("fwr_drop", w_dropped, 1);
    chk("fwr_head", r_data, 8'hB1);
    chk("fwr_full", w_full, 0);
    for (int i = 0; i < 3; i++) begin
      chk("fwr_drain", r_data, 8'hB1 + 8'(i));
      step(1'b0, 8'h00, 1'b1);
    end
    chk("fwr_empty", r_empty, 1);
    chk("fwr_dcnt", drop_cnt, ONE_IF_STATS * CW'(2));

    // prefill 2, then stream 20 across pointer wrap
    step(1'b1, 8'h80, 1'b0);
    step(1'b1, 8'h81, 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk("strm_head", r_data, 8'h80 + 8'(i));
      step(1'b1, 8'h82 + 8'(i), 1'b1);
      chk("strm_count", count, 2);
      chk_ptrs("strm_ptrdiff");
    end

    // async reset mid-stream at count 3
    step(1'b1, 8'hC0, 1'b0);
    chk("mid_count", count, 3);
    rst_n = 1'b0;
    #2;
    chk("arst_count", count, 0);
    chk("arst_empty", r_empty, 1);
    chk("arst_full", w_full, 0);
    chk_ptrs("arst_ptrdiff");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 8'h7E, 1'b0);
    chk("post_data", r_data, 8'h7E);
    chk("post_count", count, 1);
    chk("post_dcnt", drop_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
